// File: rtl/exec_unit_mc.sv
// exec_unit_mc: handshaked RISC-V execute stage with a registered result.
// Single-cycle integer ALU (RV32I/RV64I ops, LUI, AUIPC, load/store address).
// Optional macro EXEC_MDU_EN adds an iterative M-extension multiply/divide
// unit (shift-add multiply, restoring divide, one bit per cycle).
module exec_unit_mc #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  read_data1,
   input  logic [XLEN-1:0]  read_data2,
   input  logic [XLEN-1:0]  imm,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out
);
   localparam int SH = $clog2(XLEN);
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_next;
   logic [XLEN-1:0]   result_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic              accept;
   logic              mdu_start;
   logic              mdu_last;
   logic [XLEN-1:0]   alu_result;
   logic [XLEN-1:0]   mdu_result;
   logic [SH-1:0]     shamt_i, shamt_r;

   assign in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = ~rst & (state == DONE);
   assign result    = result_reg;
   assign tag_out   = tag_reg;
   assign shamt_i   = imm[SH-1:0];
   assign shamt_r   = read_data2[SH-1:0];

`ifdef EXEC_MDU_EN
   // Fast-path detection for divides that need no iteration
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] fast_result;
   assign div_zero = (read_data2 == '0);
   assign div_ovf  = ~funct3[0] & (read_data1 == MIN_VAL) & (read_data2 == '1);
   assign fast_result = div_zero ? (funct3[1] ? read_data1 : '1)
                                 : (funct3[1] ? '0 : MIN_VAL);
`endif

   // Single-cycle ALU decode; also flags ops that need the iterative unit
   always_comb begin
      alu_result = '0;
      mdu_start  = 1'b0;
      case (opcode)
         OPC_OPIMM: begin
            case (funct3)
               3'b000: alu_result = read_data1 + imm;
               3'b010: alu_result = {{(XLEN-1){1'b0}}, $signed(read_data1) < $signed(imm)};
               3'b011: alu_result = {{(XLEN-1){1'b0}}, read_data1 < imm};
               3'b100: alu_result = read_data1 ^ imm;
               3'b110: alu_result = read_data1 | imm;
               3'b111: alu_result = read_data1 & imm;
               3'b001: alu_result = read_data1 << shamt_i;
               3'b101: alu_result = funct7[5] ? XLEN'($signed(read_data1) >>> shamt_i)
                                              : read_data1 >> shamt_i;
               default: alu_result = '0;
            endcase
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: alu_result = read_data1 + read_data2;
                  3'b001: alu_result = read_data1 << shamt_r;
                  3'b010: alu_result = {{(XLEN-1){1'b0}}, $signed(read_data1) < $signed(read_data2)};
                  3'b011: alu_result = {{(XLEN-1){1'b0}}, read_data1 < read_data2};
                  3'b100: alu_result = read_data1 ^ read_data2;
                  3'b101: alu_result = read_data1 >> shamt_r;
                  3'b110: alu_result = read_data1 | read_data2;
                  default: alu_result = read_data1 & read_data2;
               endcase
            end else if (funct7 == 7'b0100000) begin
               if (funct3 == 3'b000)
                  alu_result = read_data1 - read_data2;
               else if (funct3 == 3'b101)
                  alu_result = XLEN'($signed(read_data1) >>> shamt_r);
            end
`ifdef EXEC_MDU_EN
            else if (funct7 == 7'b0000001) begin
               if (funct3[2] & (div_zero | div_ovf))
                  alu_result = fast_result;
               else
                  mdu_start = 1'b1;
            end
`endif
         end
         OPC_LOAD, OPC_STORE: alu_result = read_data1 + imm;
         OPC_LUI:             alu_result = imm;
         OPC_AUIPC:           alu_result = pc + imm;
         default:             alu_result = '0;
      endcase
   end

`ifdef EXEC_MDU_EN
   logic [SH-1:0]     cnt_reg;
   logic [2:0]        f3_reg;
   logic              neg_q_reg, neg_r_reg;
   logic [2*XLEN-1:0] acc_reg, mcand_reg;
   logic [XLEN-1:0]   mplier_reg, rem_reg, dvsr_reg;
   logic              rs1_s, rs2_s, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] acc_step, prod;
   logic [XLEN:0]     shifted, diff;
   logic              qbit;
   logic [XLEN-1:0]   rem_step, quo_step;

   assign rs1_s = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign rs2_s = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign a_neg = rs1_s & read_data1[XLEN-1];
   assign b_neg = rs2_s & read_data2[XLEN-1];
   assign a_mag = a_neg ? -read_data1 : read_data1;
   assign b_mag = b_neg ? -read_data2 : read_data2;

   assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign prod     = neg_q_reg ? -acc_step : acc_step;
   assign shifted  = {rem_reg, mplier_reg[XLEN-1]};
   assign diff     = shifted - {1'b0, dvsr_reg};
   assign qbit     = ~diff[XLEN];
   assign rem_step = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign quo_step = {mplier_reg[XLEN-2:0], qbit};
   assign mdu_last = (state == BUSY) & (cnt_reg == '0);

   // Final sign fix-up and selection of the requested half / quotient / remainder
   always_comb begin
      mdu_result = '0;
      case (f3_reg)
         3'b000:                 mdu_result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: mdu_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         mdu_result = neg_q_reg ? -quo_step : quo_step;
         default:                mdu_result = neg_r_reg ? -rem_step : rem_step;
      endcase
   end

   // Iterative multiply/divide datapath: load magnitudes on accept, one bit per BUSY cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (accept & mdu_start) begin
         cnt_reg    <= SH'(XLEN-1);
         f3_reg     <= funct3;
         neg_q_reg  <= a_neg ^ b_neg;
         neg_r_reg  <= a_neg;
         acc_reg    <= '0;
         mcand_reg  <= {{XLEN{1'b0}}, a_mag};
         rem_reg    <= '0;
         dvsr_reg   <= b_mag;
         mplier_reg <= funct3[2] ? a_mag : b_mag;
      end else if (state == BUSY) begin
         cnt_reg <= cnt_reg - 1'b1;
         if (f3_reg[2]) begin
            rem_reg    <= rem_step;
            mplier_reg <= quo_step;
         end else begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
         end
      end
   end
`else
   assign mdu_last   = 1'b0;
   assign mdu_result = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic for the handshake FSM
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = mdu_start ? BUSY : DONE;
         BUSY: if (mdu_last) state_next = DONE;
         DONE: if (out_ready) state_next = accept ? (mdu_start ? BUSY : DONE) : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result and tag registers, held stable while the result waits in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= '0;
         tag_reg    <= '0;
      end else if (accept) begin
         tag_reg <= tag_in;
         if (!mdu_start) result_reg <= alu_result;
      end else if (mdu_last) begin
         result_reg <= mdu_result;
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed testbench for exec_unit_mc (XLEN=32); MDU cases run when EXEC_MDU_EN is defined.
module tb_exec_unit_mc;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111;

   logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [6:0]       opcode, funct7;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  pc, read_data1, read_data2, imm, result;
   logic [TAG_W-1:0] tag_in, tag_out;
   int checks = 0;
   int errors = 0;

   exec_unit_mc #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .pc(pc),
      .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
      .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .tag_out(tag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
                        input logic [31:0] pcv, input logic [4:0] tg);
      in_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
      read_data1 = rs1; read_data2 = rs2; imm = im; pc = pcv; tag_in = tg;
   endtask

   // Present an op, expect it accepted this cycle and its result one cycle later
   task automatic run1(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] im, input logic [31:0] pcv, input logic [4:0] tg,
                       input logic [31:0] exp);
      drive(op, f3, f7, rs1, rs2, im, pcv, tg);
      #1;
      chk({name, ".in_ready"}, in_ready, 1);
      tick();
      chk({name, ".out_valid"}, out_valid, 1);
      chk({name, ".result"}, result, exp);
      chk({name, ".tag"}, tag_out, tg);
      $display("op %s tag=%0d result=%h", name, tag_out, result);
   endtask

`ifdef EXEC_MDU_EN
   task automatic run_mc(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] tg, input logic [31:0] exp,
                         input int exp_lat);
      int lat;
      drive(OP, f3, 7'b0000001, rs1, rs2, 0, 0, tg);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({name, ".latency"}, lat, exp_lat);
      chk({name, ".result"}, result, exp);
      chk({name, ".tag"}, tag_out, tg);
      $display("mdu %s tag=%0d result=%h latency=%0d", name, tag_out, result, lat);
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; funct3 = '0; funct7 = '0; pc = '0;
      read_data1 = '0; read_data2 = '0; imm = '0; tag_in = '0;
      tick();
      tick();
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.result", result, 0);
      chk("rst.tag", tag_out, 0);
      rst = 1'b0;
      #1;
      chk("post_rst.in_ready", in_ready, 1);

      // Back-to-back single-cycle ops, one result per cycle
      run1("ADDI",  OPIMM, 3'b000, 7'h00, 32'h7FFFFFFF, 0, 1, 0, 1, 32'h80000000);
      run1("SLTI",  OPIMM, 3'b010, 7'h00, 32'hFFFFFFFF, 0, 0, 0, 2, 32'h1);
      run1("SLTIU", OPIMM, 3'b011, 7'h00, 32'hFFFFFFFF, 0, 0, 0, 3, 32'h0);
      run1("SRA",   OP,    3'b101, 7'h20, 32'h80000000, 31, 0, 0, 4, 32'hFFFFFFFF);
      run1("SRL",   OP,    3'b101, 7'h00, 32'h80000000, 31, 0, 0, 5, 32'h00000001);
      run1("SUB",   OP,    3'b000, 7'h20, 5, 7, 0, 0, 6, 32'hFFFFFFFE);
      run1("ADDwrap", OP,  3'b000, 7'h00, 32'hFFFFFFFF, 1, 0, 0, 7, 32'h0);
      run1("SLLI",  OPIMM, 3'b001, 7'h00, 1, 0, 4, 0, 8, 32'h10);
      run1("SRAI",  OPIMM, 3'b101, 7'h20, 32'h80000000, 0, 4, 0, 9, 32'hF8000000);
      run1("SRLI",  OPIMM, 3'b101, 7'h00, 32'h80000000, 0, 4, 0, 10, 32'h08000000);
      run1("XORI",  OPIMM, 3'b100, 7'h00, 32'hF0F0, 0, 32'hFF, 0, 11, 32'hF00F);
      run1("ORI",   OPIMM, 3'b110, 7'h00, 32'hF0, 0, 32'h0F, 0, 12, 32'hFF);
      run1("ANDI",  OPIMM, 3'b111, 7'h00, 32'hF0, 0, 32'h3C, 0, 13, 32'h30);
      run1("SLLwrap", OP,  3'b001, 7'h00, 3, 33, 0, 0, 14, 32'h6);
      run1("SLT",   OP,    3'b010, 7'h00, 32'hFFFFFFFF, 1, 0, 0, 15, 32'h1);
      run1("SLTU",  OP,    3'b011, 7'h00, 32'hFFFFFFFF, 1, 0, 0, 16, 32'h0);
      run1("XOR",   OP,    3'b100, 7'h00, 32'hAA, 32'h0F, 0, 0, 17, 32'hA5);
      run1("AUIPC", AUIPC, 3'b000, 7'h00, 0, 0, 32'h2000, 32'h1000, 18, 32'h3000);
      run1("LUI",   LUI,   3'b000, 7'h00, 32'h5, 0, 32'h12345000, 0, 19, 32'h12345000);
      run1("BADOPC", 7'b1111111, 3'b000, 7'h00, 9, 9, 9, 9, 20, 32'h0);
      run1("LOAD",  LOAD,  3'b010, 7'h00, 32'h100, 0, 32'hFFFFFFFC, 0, 21, 32'hFC);
      run1("STORE", STORE, 3'b010, 7'h00, 32'h8, 0, 32'h10, 0, 22, 32'h18);
      run1("BADF7", OP,    3'b111, 7'h20, 32'hFF, 32'hFF, 0, 0, 23, 32'h0);
`ifndef EXEC_MDU_EN
      run1("MUL_off", OP,  3'b000, 7'h01, 6, 7, 0, 0, 24, 32'h0);
`endif
      in_valid = 1'b0;
      tick();
      chk("drain.out_valid", out_valid, 0);

      // Backpressure: result and tag held while out_ready=0
      run1("ADDstall", OP, 3'b000, 7'h00, 3, 4, 0, 0, 25, 32'h7);
      out_ready = 1'b0;
      drive(OP, 3'b000, 7'h00, 10, 20, 0, 0, 26);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall.out_valid", out_valid, 1);
         chk("stall.result", result, 7);
         chk("stall.tag", tag_out, 25);
         chk("stall.in_ready", in_ready, 0);
         $display("stall cycle %0d tag=%0d result=%h", i, tag_out, result);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("release.in_ready", in_ready, 1);
      tick();
      chk("release.result", result, 30);
      chk("release.tag", tag_out, 26);
      in_valid = 1'b0;
      tick();

      // Reset while a result is parked in DONE
      run1("ADDrst", OP, 3'b000, 7'h00, 1, 2, 0, 0, 27, 32'h3);
      in_valid = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstdone.out_valid", out_valid, 0);
      chk("rstdone.in_ready", in_ready, 0);
      tick();
      chk("rstdone.result", result, 0);
      chk("rstdone.tag", tag_out, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rstdone.in_ready_after", in_ready, 1);
      tick();
      chk("rstdone.no_output", out_valid, 0);

`ifdef EXEC_MDU_EN
      run_mc("MUL",    3'b000, 6, 7, 1, 32'd42, 33);
      run_mc("DIV",    3'b100, 32'hFFFFFFF9, 2, 2, 32'hFFFFFFFD, 33);
      run_mc("REM",    3'b110, 32'hFFFFFFF9, 2, 3, 32'hFFFFFFFF, 33);
      run_mc("DIVU0",  3'b101, 32'h1234, 0, 4, 32'hFFFFFFFF, 1);
      run_mc("REMU0",  3'b111, 32'h1234, 0, 5, 32'h1234, 1);
      run_mc("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 6, 32'h80000000, 1);
      run_mc("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 32'hFFFFFFFE, 33);
      run_mc("MULH",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 32'h0, 33);

      // Reset during BUSY discards the divide
      begin
         int seen;
         drive(OP, 3'b100, 7'b0000001, 100, 7, 0, 0, 9);
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < 5; i++) tick();
         chk("busy.in_ready", in_ready, 0);
         rst = 1'b1;
         tick();
         chk("busyrst.out_valid", out_valid, 0);
         chk("busyrst.result", result, 0);
         rst = 1'b0;
         #1;
         chk("busyrst.in_ready", in_ready, 1);
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
         end
         chk("busyrst.never_out", seen, 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
